stopwatch_ctrl: RTL and testbench

Controller that sequences a seconds time base into a start/stop/pause stopwatch. It has an internal prescaler that issues one tick per TICK_DIV clocks while running. It also keeps an mm:ss BCD count for the board's 7-segment display driver. It sits between the debounced push-buttons and the display mux, and replaces free-running 1 s dividers wherever the count must be gated.

---
 rtl/stopwatch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// mm:ss BCD stopwatch with start/stop/pause FSM and gated seconds prescaler.
// Optional lap-hold display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
    output logic       lap_hold,
`endif
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [3:0]  s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic        tick_q, tick_d, wrap_q, wrap_d;
    logic        btn_ss_q, btn_clr_q;
    logic        press_ss, press_clr, tick_now;

    assign press_ss  = btn_start_stop & ~btn_ss_q;
    assign press_clr = btn_clear & ~btn_clr_q;
    assign tick_now  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    // The prescaler advances on every edge that leaves the FSM in RUN (entry
    // and resume edges included); the pause edge holds it, so no time is lost.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        s1_d    = s1_q;
        s10_d   = s10_q;
        m1_d    = m1_q;
        m10_d   = m10_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                s1_d    = '0;
                s10_d   = '0;
                m1_d    = '0;
                m10_d   = '0;
                if (press_ss) begin
                    state_d = ST_RUN;
                    presc_d = 32'd1;
                end
            end
            ST_RUN: begin
                if (tick_now) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (s1_q == 4'd9) begin
                        s1_d = '0;
                        if (s10_q == 4'd5) begin
                            s10_d = '0;
                            if (m1_q == 4'd9) begin
                                m1_d = '0;
                                if (m10_q == 4'd5) begin
                                    m10_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    m10_d = m10_q + 4'd1;
                                end
                            end else begin
                                m1_d = m1_q + 4'd1;
                            end
                        end else begin
                            s10_d = s10_q + 4'd1;
                        end
                    end else begin
                        s1_d = s1_q + 4'd1;
                    end
                end else if (!press_ss) begin
                    presc_d = presc_q + 32'd1;
                end
                if (press_ss) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press_clr) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    s1_d    = '0;
                    s10_d   = '0;
                    m1_d    = '0;
                    m10_d   = '0;
                end else if (press_ss) begin
                    state_d = ST_RUN;
                    presc_d = presc_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            s1_q      <= '0;
            s10_q     <= '0;
            m1_q      <= '0;
            m10_q     <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            btn_ss_q  <= 1'b0;
            btn_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            s1_q      <= s1_d;
            s10_q     <= s10_d;
            m1_q      <= m1_d;
            m10_q     <= m10_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            btn_ss_q  <= btn_start_stop;
            btn_clr_q <= btn_clear;
        end
    end

    assign running = (state_q == ST_RUN);
    assign tick    = tick_q;
    assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic        btn_lap_q, lap_q, lap_d, press_lap;
    logic [15:0] disp_q, disp_d;

    assign press_lap = btn_lap & ~btn_lap_q;

    // Display register tracks the next count unless a hold is already active.
    always_comb begin
        lap_d = lap_q;
        if (state_d != ST_RUN) begin
            lap_d = 1'b0;
        end else if ((state_q == ST_RUN) && press_lap) begin
            lap_d = ~lap_q;
        end
        disp_d = (lap_q && lap_d) ? disp_q : {m10_d, m1_d, s10_d, s1_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_lap_q <= 1'b0;
            lap_q     <= 1'b0;
            disp_q    <= '0;
        end else begin
            btn_lap_q <= btn_lap;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
        end
    end

    assign lap_hold = lap_q;
    assign min_tens = disp_q[15:12];
    assign min_ones = disp_q[11:8];
    assign sec_tens = disp_q[7:4];
    assign sec_ones = disp_q[3:0];
`else
    assign min_tens = m10_q;
    assign min_ones = m1_q;
    assign sec_tens = s10_q;
    assign sec_ones = s1_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4); lap checks only when
// STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start_stop;
    logic       btn_clear;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap;
    logic       lap_hold;
`endif
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, tick, wrap;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap        (btn_lap),
        .lap_hold       (lap_hold),
`endif
        .sec_ones       (sec_ones),
        .sec_tens       (sec_tens),
        .min_ones       (min_ones),
        .min_tens       (min_tens),
        .running        (running),
        .tick           (tick),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int secs;
        bit wrap;
        bit run;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(string name, int act, int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endfunction

    function automatic void check_disp(string name, int secs);
        check({name, "_sec_ones"}, int'(sec_ones), (secs % 60) % 10);
        check({name, "_sec_tens"}, int'(sec_tens), (secs % 60) / 10);
        check({name, "_min_ones"}, int'(min_ones), (secs / 60) % 10);
        check({name, "_min_tens"}, int'(min_tens), secs / 600);
    endfunction

    function automatic void push_exp(int c, int s, bit w, bit r);
        exp_t e;
        e.cyc  = c;
        e.secs = s;
        e.wrap = w;
        e.run  = r;
        exp_q.push_back(e);
    endfunction

    // Monitor: every tick pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_tick", int'(tick), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check_disp("tick", e.secs);
                check("tick_wrap", int'(wrap), int'(e.wrap));
                check("tick_running", int'(running), int'(e.run));
            end
        end else if (wrap === 1'b1) begin
            check("wrap_without_tick", int'(wrap), 0);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Raise the selected buttons for one cycle; returns the sampling edge number.
    task automatic press(input bit ss, input bit clr, input bit lap, output int edge_n);
        edge_n = cyc + 1;
        btn_start_stop = ss;
        btn_clear      = clr;
`ifdef STOPWATCH_LAP_EN
        btn_lap        = lap;
`endif
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap        = 1'b0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e_st, p_ed, r_ed, w_cyc, q_ed, s_ed, t_ed, dummy;
        rst            = 1'b1;
        btn_start_stop = 1'b1;
        btn_clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap        = 1'b1;
`endif
        @(negedge clk);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b1;
        @(negedge clk);
        check_disp("reset", 0);
        check("reset_running", int'(running), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_wrap", int'(wrap), 0);
        rst       = 1'b0;
        btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap   = 1'b0;
`endif
        @(negedge clk);
        check("idle_running", int'(running), 0);

        press(1'b0, 1'b1, 1'b0, dummy);
        check("idle_clear_running", int'(running), 0);
        check_disp("idle_clear", 0);

        wait_until(6);
        press(1'b1, 1'b0, 1'b0, e_st);
        check("start_running", int'(running), 1);
        for (int k = 1; k <= 10; k++) push_exp(e_st + 4 * k - 1, k, 1'b0, 1'b1);

        // Pause two cycles after the tenth tick.
        wait_until(e_st + 40);
        press(1'b1, 1'b0, 1'b0, p_ed);
        check("pause_running", int'(running), 0);
        check_disp("pause_entry", 10);
        wait_until(p_ed + 19);
        check("paused_running", int'(running), 0);
        check_disp("paused", 10);

        press(1'b1, 1'b0, 1'b0, r_ed);
        check("resume_running", int'(running), 1);
        push_exp(r_ed + 2, 11, 1'b0, 1'b1);
        for (int k = 12; k <= 3603; k++)
            push_exp(r_ed + 2 + 4 * (k - 11), k % 3600, (k == 3600), 1'b1);
        w_cyc = r_ed + 2 + 4 * 3589;

        // Clear while running is ignored.
        wait_until(w_cyc + 8);
        press(1'b0, 1'b1, 1'b0, dummy);
        check("run_clear_running", int'(running), 1);
        check_disp("run_clear", 2);

        wait_until(w_cyc + 12);
        press(1'b1, 1'b0, 1'b0, dummy);
        check("pause2_running", int'(running), 0);
        wait_until(w_cyc + 20);
        check_disp("pause2", 3);

        press(1'b1, 1'b1, 1'b0, q_ed);
        check("both_running", int'(running), 0);
        check_disp("both_clear", 0);

        // Pause press on the same edge as a tick.
        wait_until(q_ed + 2);
        press(1'b1, 1'b0, 1'b0, s_ed);
        push_exp(s_ed + 3, 1, 1'b0, 1'b0);
        wait_until(s_ed + 2);
        press(1'b1, 1'b0, 1'b0, dummy);
        wait_until(s_ed + 6);
        check_disp("tick_pause_hold", 1);
        push_exp(s_ed + 10, 2, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0, t_ed);
        check("resume2_running", int'(running), 1);

        wait_until(s_ed + 11);
        rst = 1'b1;
        @(negedge clk);
        check_disp("midrun_reset", 0);
        check("midrun_reset_running", int'(running), 0);
        check("midrun_reset_tick", int'(tick), 0);
        rst = 1'b0;

`ifdef STOPWATCH_LAP_EN
        begin
            int l_ed;
            wait_until(s_ed + 14);
            press(1'b1, 1'b0, 1'b0, l_ed);
            for (int k = 1; k <= 3; k++) push_exp(l_ed + 4 * k - 1, k, 1'b0, 1'b1);
            for (int k = 4; k <= 8; k++) push_exp(l_ed + 4 * k - 1, 3, 1'b0, 1'b1);
            wait_until(l_ed + 11);
            press(1'b0, 1'b0, 1'b1, dummy);
            check("lap_hold_set", int'(lap_hold), 1);
            check_disp("lap_frozen", 3);
            wait_until(l_ed + 31);
            press(1'b0, 1'b0, 1'b1, dummy);
            check("lap_hold_clr", int'(lap_hold), 0);
            check_disp("lap_live", 8);
            push_exp(l_ed + 35, 9, 1'b0, 1'b1);
            wait_until(l_ed + 36);
            press(1'b1, 1'b0, 1'b0, dummy);
        end
`endif

        repeat (6) @(negedge clk);
        check("pending_ticks", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
